// File: rtl/tone_sequencer.sv
// Song sequencer: walks a registered note ROM of {dur, half_period} entries,
// drives the tone generator, inserts a silent gap per note and handles play/pause.
module tone_sequencer #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int GAP_TICKS      = 20,
    parameter int AW             = 4
) (
    input  logic          sysclk,
    input  logic          sw0,
    input  logic          button0,
    input  logic          button1,
    output logic [AW-1:0] rom_addr,
    input  logic [27:0]   rom_data,
    output logic [19:0]   half_period,
    output logic          tone_en,
    output logic          busy,
    output logic [3:0]    leds
);
    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int TW  = $clog2(TICK_CYC + 1);
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int GW  = $clog2(GAP_TICKS + 1);
    localparam int SW  = (GW > 8) ? GW : 8;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, PAUSE} state_t;

    state_t          state;
    state_t          resume;
    logic [AW-1:0]   addr;
    logic [7:0]      dur;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   step_cnt;
    logic [TW-1:0]   tick_cnt_adv;
    logic [SW-1:0]   step_cnt_adv;
    logic            tick;
    logic            step_last;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic            deb0_q;
    logic [DBW-1:0]  db_cnt [2];
    logic [TW-1:0]   db_tick_cnt;
    logic            db_tick;
    logic            press;
    logic [AW+3:0]   addr_ext;

    // The debouncers run on their own free-running tick so that clearing the
    // note prescaler never disturbs button timing.
    assign db_tick = (db_tick_cnt == TW'(TICK_CYC - 1));
    assign press   = deb[0] & ~deb0_q;

    always_ff @(posedge sysclk or posedge sw0) begin
        if (sw0) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            deb0_q      <= 1'b0;
            db_tick_cnt <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1       <= {button1, button0};
            sync2       <= sync1;
            deb0_q      <= deb[0];
            db_tick_cnt <= db_tick ? '0 : db_tick_cnt + TW'(1);
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_tick) begin
                    if (db_cnt[i] == DBW'(DEBOUNCE_TICKS - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end
            end
        end
    end

    assign tick         = (tick_cnt == TW'(TICK_CYC - 1));
    assign tick_cnt_adv = tick ? '0 : tick_cnt + TW'(1);
    assign step_cnt_adv = tick ? step_cnt + SW'(1) : step_cnt;
    assign step_last    = (state == PLAY) ? (step_cnt == SW'(dur) - SW'(1))
                                          : (step_cnt == SW'(GAP_TICKS - 1));

    always_ff @(posedge sysclk or posedge sw0) begin
        if (sw0) begin
            state       <= IDLE;
            resume      <= FETCH;
            addr        <= '0;
            dur         <= '0;
            tick_cnt    <= '0;
            step_cnt    <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (press) begin
                    addr  <= '0;
                    busy  <= 1'b1;
                    state <= FETCH;
                end
                FETCH, LATCH: begin
                    if (press) begin
                        resume <= FETCH;
                        state  <= PAUSE;
                    end else if (state == FETCH) begin
                        state <= LATCH;
                    end else if (rom_data[27:20] == 8'd0) begin
                        addr <= '0;
                        if (deb[1]) begin
                            state <= FETCH;
                        end else begin
                            half_period <= '0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end else begin
                        dur         <= rom_data[27:20];
                        half_period <= rom_data[19:0];
                        tone_en     <= (rom_data[19:0] != 20'd0);
                        tick_cnt    <= '0;
                        step_cnt    <= '0;
                        state       <= PLAY;
                    end
                end
                PLAY, GAP: begin
                    // A press on the final tick freezes the counters just short of
                    // the transition, so it happens on the first cycle after resume.
                    if (press) begin
                        resume  <= state;
                        tone_en <= 1'b0;
                        state   <= PAUSE;
                        if (!(tick && step_last)) begin
                            tick_cnt <= tick_cnt_adv;
                            step_cnt <= step_cnt_adv;
                        end
                    end else if (tick && step_last) begin
                        tick_cnt <= '0;
                        step_cnt <= '0;
                        tone_en  <= 1'b0;
                        if (state == PLAY) begin
                            state <= GAP;
                        end else begin
                            addr  <= addr + AW'(1);
                            state <= FETCH;
                        end
                    end else begin
                        tick_cnt <= tick_cnt_adv;
                        step_cnt <= step_cnt_adv;
                    end
                end
                PAUSE: if (press) begin
                    tone_en <= (resume == PLAY) && (half_period != 20'd0);
                    state   <= resume;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rom_addr = addr;
    assign addr_ext = {4'b0000, addr};
    assign leds     = busy ? addr_ext[3:0] : 4'b0000;
endmodule
